// File: rtl/contrast_ctrl.sv
// contrast_ctrl: frame-synchronous contrast factor controller.
// Config valid/ready in, SOF-committed factor out, frame/line stats.
//
// Ports:
//   I_clk, I_rst_n           clock, async active-low reset
//   I_cfg_valid/I_cfg_level  config request (Q1.7), O_cfg_ready
//   I_tvalid/I_tready        monitored stream handshake
//   I_tuser/I_tlast          monitored SOF / EOL
//   O_contrast_level         factor to the contrast datapath
//   O_busy                   update pending or ramping
//   O_frame_cnt              SOF beats seen, wraps
//   O_line_cnt               lines in last completed frame, saturates
//
// Build option: define CONTRAST_RAMP_EN for multi-frame ramping of
// at most RAMP_STEP per frame; otherwise target applies at one SOF.
module contrast_ctrl #(
  parameter int unsigned DEFAULT_LEVEL = 128,
  parameter int unsigned LEVEL_MIN     = 32,
  parameter int unsigned LEVEL_MAX     = 255,
  parameter int unsigned RAMP_STEP     = 8
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_cfg_valid,
  input  logic [7:0]  I_cfg_level,
  output logic        O_cfg_ready,
  input  logic        I_tvalid,
  input  logic        I_tready,
  input  logic        I_tuser,
  input  logic        I_tlast,
  output logic [7:0]  O_contrast_level,
  output logic        O_busy,
  output logic [15:0] O_frame_cnt,
  output logic [11:0] O_line_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND
`ifdef CONTRAST_RAMP_EN
    , ST_RAMP
`endif
  } state_t;

  localparam logic [7:0] DEF_L = 8'(DEFAULT_LEVEL);
  localparam logic [8:0] MIN9  = 9'(LEVEL_MIN);
  localparam logic [8:0] MAX9  = 9'(LEVEL_MAX);

  state_t      state;
  logic [7:0]  target;
  logic [7:0]  cfg_clamped;
  logic [11:0] line_run;
  logic        beat;
  logic        sof;
  logic        eol;
  logic        cfg_acc;

  assign beat    = I_tvalid & I_tready;
  assign sof     = beat & I_tuser;
  assign eol     = beat & I_tlast;
  assign cfg_acc = I_cfg_valid & O_cfg_ready;

  // 9-bit compares keep the clamp meaningful for any 8-bit bounds
  always_comb begin
    cfg_clamped = I_cfg_level;
    if ({1'b0, I_cfg_level} < MIN9)
      cfg_clamped = MIN9[7:0];
    else if ({1'b0, I_cfg_level} > MAX9)
      cfg_clamped = MAX9[7:0];
  end

`ifdef CONTRAST_RAMP_EN
  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

  logic [8:0] lvl9;
  logic [8:0] tgt9;
  logic [8:0] diff9;
  logic [8:0] step9;
  logic [8:0] nxt9;
  logic [7:0] ramp_next;
  logic       up;
  logic       unused_msb;

  // step is min(RAMP_STEP, distance), so target is never overshot
  always_comb begin
    lvl9  = {1'b0, O_contrast_level};
    tgt9  = {1'b0, target};
    up    = (tgt9 >= lvl9);
    diff9 = up ? (tgt9 - lvl9) : (lvl9 - tgt9);
    step9 = (diff9 > STEP9) ? STEP9 : diff9;
    nxt9  = up ? (lvl9 + step9) : (lvl9 - step9);
  end

  assign ramp_next  = nxt9[7:0];
  assign unused_msb = nxt9[8];
`else
  logic [8:0] unused_step;
  assign unused_step = 9'(RAMP_STEP);
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state            <= ST_IDLE;
      target           <= DEF_L;
      O_contrast_level <= DEF_L;
      O_cfg_ready      <= 1'b1;
      O_busy           <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cfg_acc) begin
            target      <= cfg_clamped;
            state       <= ST_PEND;
            O_cfg_ready <= 1'b0;
            O_busy      <= 1'b1;
          end
        end
`ifdef CONTRAST_RAMP_EN
        ST_PEND, ST_RAMP: begin
          if (sof) begin
            O_contrast_level <= ramp_next;
            if (ramp_next == target) begin
              state       <= ST_IDLE;
              O_cfg_ready <= 1'b1;
              O_busy      <= 1'b0;
            end else begin
              state <= ST_RAMP;
            end
          end
        end
`else
        ST_PEND: begin
          if (sof) begin
            O_contrast_level <= target;
            state            <= ST_IDLE;
            O_cfg_ready      <= 1'b1;
            O_busy           <= 1'b0;
          end
        end
`endif
        default: begin
          state       <= ST_IDLE;
          O_cfg_ready <= 1'b1;
          O_busy      <= 1'b0;
        end
      endcase
    end
  end

  // SOF closes the previous frame; its own EOL opens the new count
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_frame_cnt <= '0;
      O_line_cnt  <= '0;
      line_run    <= '0;
    end else begin
      if (sof) begin
        O_frame_cnt <= O_frame_cnt + 16'd1;
        O_line_cnt  <= line_run;
        line_run    <= {11'd0, eol};
      end else if (eol && (line_run != 12'hFFF)) begin
        line_run <= line_run + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_contrast_ctrl.sv
// tb_contrast_ctrl: directed self-checking bench for contrast_ctrl.
// Expected values are hand-computed for the default parameters.
module tb_contrast_ctrl;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_cfg_valid = 1'b0;
  logic [7:0]  I_cfg_level = 8'd0;
  logic        O_cfg_ready;
  logic        I_tvalid = 1'b0;
  logic        I_tready = 1'b1;
  logic        I_tuser = 1'b0;
  logic        I_tlast = 1'b0;
  logic [7:0]  O_contrast_level;
  logic        O_busy;
  logic [15:0] O_frame_cnt;
  logic [11:0] O_line_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_sof = 0;

  always #5 I_clk = ~I_clk;

  contrast_ctrl dut (
    .I_clk            (I_clk),
    .I_rst_n          (I_rst_n),
    .I_cfg_valid      (I_cfg_valid),
    .I_cfg_level      (I_cfg_level),
    .O_cfg_ready      (O_cfg_ready),
    .I_tvalid         (I_tvalid),
    .I_tready         (I_tready),
    .I_tuser          (I_tuser),
    .I_tlast          (I_tlast),
    .O_contrast_level (O_contrast_level),
    .O_busy           (O_busy),
    .O_frame_cnt      (O_frame_cnt),
    .O_line_cnt       (O_line_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    I_tvalid    = 1'b0;
    I_tready    = 1'b1;
    I_tuser     = 1'b0;
    I_tlast     = 1'b0;
    I_cfg_valid = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic r,
                     input logic u, input logic l);
    I_tvalid = v;
    I_tready = r;
    I_tuser  = u;
    I_tlast  = l;
    @(posedge I_clk);
    if (v && r && u) n_sof++;
    #1;
    idle_bus();
  endtask

  task automatic sof();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] v);
    I_cfg_valid = 1'b1;
    I_cfg_level = v;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic apply(input string tag, input logic [7:0] v,
                       input logic [7:0] exp, input int nr);
    cfg(v);
    chk({tag, "_busy"}, 32'(O_busy), 32'd1);
    chk({tag, "_rdy"}, 32'(O_cfg_ready), 32'd0);
`ifdef CONTRAST_RAMP_EN
    repeat (nr) sof();
`else
    if (nr > 0) sof();
`endif
    chk({tag, "_lvl"}, 32'(O_contrast_level), 32'(exp));
    chk({tag, "_done"}, 32'(O_busy), 32'd0);
  endtask

  task automatic do_reset();
    I_rst_n = 1'b0;
    #2;
    n_sof = 0;
    @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;
  endtask

  initial begin
    idle_bus();
    #12;
    chk("rst_lvl", 32'(O_contrast_level), 32'd128);
    chk("rst_rdy", 32'(O_cfg_ready), 32'd1);
    chk("rst_busy", 32'(O_busy), 32'd0);
    chk("rst_frm", 32'(O_frame_cnt), 32'd0);
    chk("rst_line", 32'(O_line_cnt), 32'd0);
    @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;

    for (int f = 0; f < 3; f++) begin
      sof();
      chk("nocfg_lvl", 32'(O_contrast_level), 32'd128);
      repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    end
    chk("nocfg_frm", 32'(O_frame_cnt), 32'd3);
    chk("nocfg_line", 32'(O_line_cnt), 32'd4);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cfg(8'd200);
    chk("c200_busy", 32'(O_busy), 32'd1);
    chk("c200_rdy", 32'(O_cfg_ready), 32'd0);
    chk("c200_hold", 32'(O_contrast_level), 32'd128);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("c200_hold2", 32'(O_contrast_level), 32'd128);
    sof();
    chk("c200_frm", 32'(O_frame_cnt), 32'd4);
    chk("c200_line", 32'(O_line_cnt), 32'd5);
`ifdef CONTRAST_RAMP_EN
    chk("c200_s1", 32'(O_contrast_level), 32'd136);
    chk("c200_bsy1", 32'(O_busy), 32'd1);
    repeat (8) sof();
`endif
    chk("c200_lvl", 32'(O_contrast_level), 32'd200);
    chk("c200_done", 32'(O_busy), 32'd0);
    chk("c200_rdy2", 32'(O_cfg_ready), 32'd1);

    apply("clamp_lo", 8'd10, 8'd32, 21);
    apply("clamp_hi", 8'd255, 8'd255, 28);
    apply("back128", 8'd128, 8'd128, 16);

    cfg(8'd160);
`ifdef CONTRAST_RAMP_EN
    sof();
    sof();
    chk("mid_lvl", 32'(O_contrast_level), 32'd144);
`endif
    chk("mid_busy", 32'(O_busy), 32'd1);
    I_rst_n = 1'b0;
    #2;
    n_sof = 0;
    chk("mr_lvl", 32'(O_contrast_level), 32'd128);
    chk("mr_busy", 32'(O_busy), 32'd0);
    chk("mr_rdy", 32'(O_cfg_ready), 32'd1);
    chk("mr_frm", 32'(O_frame_cnt), 32'd0);
    chk("mr_line", 32'(O_line_cnt), 32'd0);
    @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;
    sof();
    chk("mr_drop", 32'(O_contrast_level), 32'd128);
    chk("mr_frm1", 32'(O_frame_cnt), 32'd1);

    cfg(8'd160);
`ifdef CONTRAST_RAMP_EN
    for (int s = 0; s < 4; s++) begin
      sof();
      chk("ramp_lvl", 32'(O_contrast_level), 32'(136 + 8 * s));
      chk("ramp_busy", 32'(O_busy), (s < 3) ? 32'd1 : 32'd0);
    end
`else
    sof();
    chk("r160_lvl", 32'(O_contrast_level), 32'd160);
    chk("r160_busy", 32'(O_busy), 32'd0);
`endif

    I_cfg_valid = 1'b1;
    I_cfg_level = 8'd100;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("same_lvl", 32'(O_contrast_level), 32'd160);
    chk("same_busy", 32'(O_busy), 32'd1);
    chk("same_frm", 32'(O_frame_cnt), 32'(n_sof));
    sof();
`ifdef CONTRAST_RAMP_EN
    chk("same_s1", 32'(O_contrast_level), 32'd152);
    repeat (7) sof();
`endif
    chk("same_lvl2", 32'(O_contrast_level), 32'd100);
    chk("same_done", 32'(O_busy), 32'd0);

    apply("eq_tgt", 8'd100, 8'd100, 1);

    cfg(8'd64);
    I_tvalid = 1'b1;
    I_tuser  = 1'b1;
    I_tready = 1'b0;
    repeat (5) @(posedge I_clk);
    #1;
    chk("hold_lvl", 32'(O_contrast_level), 32'd100);
    chk("hold_busy", 32'(O_busy), 32'd1);
    chk("hold_frm", 32'(O_frame_cnt), 32'(n_sof));
    I_tready = 1'b1;
    @(posedge I_clk);
    n_sof++;
    #1;
    idle_bus();
    chk("hold_frm2", 32'(O_frame_cnt), 32'(n_sof));
`ifdef CONTRAST_RAMP_EN
    chk("hold_s1", 32'(O_contrast_level), 32'd92);
    repeat (4) sof();
`endif
    chk("hold_lvl2", 32'(O_contrast_level), 32'd64);
    chk("hold_done", 32'(O_busy), 32'd0);

    do_reset();
    I_tvalid = 1'b1;
    I_tuser  = 1'b1;
    repeat (65535) @(posedge I_clk);
    #1;
    idle_bus();
    chk("wrap_max", 32'(O_frame_cnt), 32'd65535);
    sof();
    chk("wrap_zero", 32'(O_frame_cnt), 32'd0);

    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    sof();
    chk("sof_eol", 32'(O_line_cnt), 32'd1);
    I_tvalid = 1'b1;
    I_tlast  = 1'b1;
    repeat (5000) @(posedge I_clk);
    #1;
    idle_bus();
    sof();
    chk("line_sat", 32'(O_line_cnt), 32'd4095);
    chk("final_lvl", 32'(O_contrast_level), 32'd128);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
